// File: rtl/scr1_tcm_acc_vadd.sv
// Memory-to-memory vector add engine (dst[i] = srcA[i] + srcB[i]) on TCM port B.
// Define SCR1_TCM_ACC_SAT_EN for signed saturating sums instead of wrapping adds.
module scr1_tcm_acc_vadd #(
  parameter int unsigned AWIDTH    = 14,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned DWIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [AWIDTH-1:0]    cfg_src_a,
  input  logic [AWIDTH-1:0]    cfg_src_b,
  input  logic [AWIDTH-1:0]    cfg_dst,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] elem_cnt,
  output logic                 mem_req,
  input  logic                 mem_grant,
  output logic                 mem_ren,
  output logic                 mem_wen,
  output logic [3:0]           mem_be,
  output logic [AWIDTH-1:0]    mem_addr,
  output logic [DWIDTH-1:0]    mem_wdata,
  input  logic [DWIDTH-1:0]    mem_rdata
);

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StWr, StDone} state_e;

  state_e                state_q;
  logic [AWIDTH-1:0]     a_q, b_q, d_q;
  logic [LEN_WIDTH-1:0]  n_q, cnt_q;
  logic                  rd_pend_q;
  logic [DWIDTH-1:0]     opa_q, opb_q;

  logic [DWIDTH-1:0]     op_b, sum_raw, sum;
  logic                  go;

  // Operand B may still be in flight on mem_rdata during the first WR cycle.
  assign op_b    = rd_pend_q ? mem_rdata : opb_q;
  assign sum_raw = opa_q + op_b;

`ifdef SCR1_TCM_ACC_SAT_EN
  logic ovf;
  assign ovf = (opa_q[DWIDTH-1] == op_b[DWIDTH-1]) && (sum_raw[DWIDTH-1] != opa_q[DWIDTH-1]);
  assign sum = !ovf            ? sum_raw :
               opa_q[DWIDTH-1] ? {1'b1, {(DWIDTH-1){1'b0}}} :
                                 {1'b0, {(DWIDTH-1){1'b1}}};
`else
  assign sum = sum_raw;
`endif

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign mem_req  = busy;
  assign elem_cnt = cnt_q;

  // Strobes are suppressed during reset so an aborted run issues no access.
  assign go = mem_grant & ~rst;

  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (go) begin
      unique case (state_q)
        StRdA: begin
          mem_ren  = 1'b1;
          mem_addr = a_q;
        end
        StRdB: begin
          mem_ren  = 1'b1;
          mem_addr = b_q;
        end
        StWr: begin
          mem_wen   = 1'b1;
          mem_be    = 4'b1111;
          mem_addr  = d_q;
          mem_wdata = sum;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      d_q       <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            a_q     <= cfg_src_a;
            b_q     <= cfg_src_b;
            d_q     <= cfg_dst;
            n_q     <= cfg_len;
            cnt_q   <= '0;
            state_q <= (cfg_len == '0) ? StDone : StRdA;
          end
        end
        StRdA: begin
          if (mem_grant) begin
            rd_pend_q <= 1'b1;
            state_q   <= StRdB;
          end
        end
        StRdB: begin
          // Capture operand A even when the grant is lost this cycle.
          if (rd_pend_q) begin
            opa_q     <= mem_rdata;
            rd_pend_q <= 1'b0;
          end
          if (mem_grant) begin
            rd_pend_q <= 1'b1;
            state_q   <= StWr;
          end
        end
        StWr: begin
          if (rd_pend_q) begin
            opb_q     <= mem_rdata;
            rd_pend_q <= 1'b0;
          end
          if (mem_grant) begin
            a_q     <= a_q + AWIDTH'(1);
            b_q     <= b_q + AWIDTH'(1);
            d_q     <= d_q + AWIDTH'(1);
            n_q     <= n_q - LEN_WIDTH'(1);
            cnt_q   <= cnt_q + LEN_WIDTH'(1);
            state_q <= (n_q == LEN_WIDTH'(1)) ? StDone : StRdA;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_tcm_acc_vadd.sv
// Randomized scoreboard bench for scr1_tcm_acc_vadd with a word-level TCM model.
// Expected reads/writes come from a sequential element-by-element reference of the vector add.
module tb_scr1_tcm_acc_vadd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [13:0] cfg_src_a = '0, cfg_src_b = '0, cfg_dst = '0;
  logic [15:0] cfg_len = '0;
  logic        busy, done, mem_req, mem_ren, mem_wen;
  logic [15:0] elem_cnt;
  logic        mem_grant = 1'b1;
  logic [3:0]  mem_be;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  scr1_tcm_acc_vadd dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_src_a (cfg_src_a),
    .cfg_src_b (cfg_src_b),
    .cfg_dst   (cfg_dst),
    .cfg_len   (cfg_len),
    .busy      (busy),
    .done      (done),
    .elem_cnt  (elem_cnt),
    .mem_req   (mem_req),
    .mem_grant (mem_grant),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int gmode    = 0;  // 0: grant always high, 1: toggle every cycle, 2: random
  logic [31:0] salt;

  logic [31:0] mem     [logic [13:0]];
  logic [31:0] ref_mem [logic [13:0]];
  logic        pl_we = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  logic [13:0] rd_q [$];
  logic [45:0] wr_q [$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [13:0] a);
    return ({18'h0, a} * 32'h9E3779B1) ^ salt;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [13:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [13:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    longint s;
    logic [63:0] sv;
    s  = longint'(int'(x)) + longint'(int'(y));
`ifdef SCR1_TCM_ACC_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    sv = s;
    return sv[31:0];
  endfunction

  // Port-B model: read data returns one cycle after an accepted read.
  always @(posedge clk) begin
    if (mem_grant && mem_ren) mem_rdata <= mem_rd(mem_addr);
    if (mem_grant && mem_wen) mem[mem_addr] = mem_wdata;
    if (pl_we) mem[pl_addr] = pl_data;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (gmode)
        0:       mem_grant = 1'b1;
        1:       mem_grant = ~mem_grant;
        default: mem_grant = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the engine presents an access.
  always @(negedge clk) begin
    if (!rst) begin
      if (!mem_grant) chk("strobe_without_grant", {mem_ren, mem_wen}, 0);
      if (mem_ren) begin
        if (rd_q.size() == 0) chk("unexpected_read", mem_addr, -1);
        else chk("read_addr", mem_addr, rd_q.pop_front());
      end
      if (mem_wen) begin
        chk("write_be", mem_be, 4'hF);
        if (wr_q.size() == 0) chk("unexpected_write", mem_addr, -1);
        else chk("write_addr_data", {mem_addr, mem_wdata}, wr_q.pop_front());
      end
    end
  end

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1;
    pl_we = 1'b0;
  endtask

  task automatic plan(input logic [13:0] a, input logic [13:0] b, input logic [13:0] d,
                      input int len);
    for (int i = 0; i < len; i++) begin
      logic [13:0] ra, rb, rw;
      logic [31:0] v;
      ra = a + 14'(i);
      rb = b + 14'(i);
      rw = d + 14'(i);
      rd_q.push_back(ra);
      rd_q.push_back(rb);
      v = ref_add(ref_rd(ra), ref_rd(rb));
      ref_mem[rw] = v;
      wr_q.push_back({rw, v});
    end
  endtask

  // exp_lat > 0: exact done latency; exp_lat < 0: zero-length bound; 0: unchecked.
  task automatic run(input logic [13:0] a, input logic [13:0] b, input logic [13:0] d,
                     input logic [15:0] len, input int exp_lat, input bit poke);
    int lat;
    bit got;
    plan(a, b, d, int'(len));
    cfg_src_a = a; cfg_src_b = b; cfg_dst = d; cfg_len = len;
    @(posedge clk);
    #1 cfg_start = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 4) begin
        cfg_start = 1'b1; cfg_len = 16'd7; cfg_src_a = a + 14'd5;
      end
      if (poke && lat == 6) begin
        cfg_start = 1'b0; cfg_len = len; cfg_src_a = a;
      end
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    if (exp_lat > 0) chk("done_latency", lat, exp_lat);
    if (exp_lat < 0) chk("zero_len_latency_le2", (lat <= 2), 1);
    if (got) begin
      chk("elem_cnt_at_done", elem_cnt, len);
      chk("busy_at_done", {busy, mem_req}, 2'b11);
      @(negedge clk);
      chk("idle_after_done", {busy, done, mem_req}, 3'b000);
    end
    chk("reads_outstanding", rd_q.size(), 0);
    chk("writes_outstanding", wr_q.size(), 0);
    gmode = 0;
  endtask

  initial begin
    salt = $urandom;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy_done_req", {busy, done, mem_req}, 3'b000);
    chk("reset_elem_cnt", elem_cnt, 0);
    chk("reset_strobes", {mem_ren, mem_wen, mem_be}, 6'b0);
    chk("reset_addr_wdata", {mem_addr, mem_wdata}, 46'h0);

    // Basic add with continuous grant.
    for (int i = 0; i < 3; i++) begin
      preload(14'h10 + 14'(i), 32'(i + 1));
      preload(14'h20 + 14'(i), 32'(10 * (i + 1)));
    end
    run(14'h10, 14'h20, 14'h30, 16'd3, 10, 1'b0);
    chk("basic_mem30", mem_rd(14'h30), 11);
    chk("basic_mem31", mem_rd(14'h31), 22);
    chk("basic_mem32", mem_rd(14'h32), 33);

    // Zero length: any access would pop an empty queue.
    run(14'h10, 14'h20, 14'h30, 16'd0, -1, 1'b0);

    // Grant toggling every cycle; grant drops right after each accepted read.
    gmode = 1;
    run(14'h100, 14'h200, 14'h300, 16'd4, 0, 1'b0);

    // Positive and negative overflow.
    preload(14'h40, 32'h7FFFFFFF);
    preload(14'h50, 32'h00000001);
    preload(14'h41, 32'h80000000);
    preload(14'h51, 32'hFFFFFFFF);
    run(14'h40, 14'h50, 14'h60, 16'd2, 0, 1'b0);
`ifdef SCR1_TCM_ACC_SAT_EN
    chk("ovf_pos", mem_rd(14'h60), 32'h7FFFFFFF);
    chk("ovf_neg", mem_rd(14'h61), 32'h80000000);
`else
    chk("ovf_pos", mem_rd(14'h60), 32'h80000000);
    chk("ovf_neg", mem_rd(14'h61), 32'h7FFFFFFF);
`endif

    // Pointer wrap with in-place destination.
    preload(14'h3FFF, 32'd5);
    preload(14'h0000, 32'd6);
    preload(14'h0100, 32'd100);
    preload(14'h0101, 32'd200);
    run(14'h3FFF, 14'h0100, 14'h3FFF, 16'd2, 0, 1'b0);
    chk("wrap_mem3fff", mem_rd(14'h3FFF), 105);
    chk("wrap_mem0000", mem_rd(14'h0000), 206);

    // Start pulse while busy must be ignored.
    run(14'h500, 14'h600, 14'h700, 16'd4, 13, 1'b1);

    // Reset during the first WR cycle: reads A0/B0 happen, no write, no done.
    rd_q.push_back(14'h800);
    rd_q.push_back(14'h900);
    cfg_src_a = 14'h800; cfg_src_b = 14'h900; cfg_dst = 14'hA00; cfg_len = 16'd4;
    @(posedge clk);
    #1 cfg_start = 1'b1;
    @(posedge clk);
    #1 cfg_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_no_write", {mem_wen, mem_ren}, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_idle", {busy, done}, 2'b00);
    end
    chk("rst_elem_cnt", elem_cnt, 0);
    chk("rst_reads_done", rd_q.size(), 0);
    chk("rst_dst_untouched", mem_rd(14'hA00), init_val(14'hA00));

    // Randomized runs with random grant patterns and arbitrary overlap.
    for (int r = 0; r < 12; r++) begin
      gmode = $urandom_range(0, 2);
      run(14'($urandom), 14'($urandom), 14'($urandom), 16'($urandom_range(1, 8)), 0, 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
